// File: rtl/cpu_pkg.sv
// cpu_pkg: datapath-wide word width and word type shared by all registers
package cpu_pkg;
  localparam int DATA_WIDTH = 32;
  typedef logic [DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/mdr_mux.sv
// mdr_mux: selects memory data during reads, otherwise the CPU bus
module mdr_mux
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             read,
  input  logic [WIDTH-1:0] bus_out,
  input  logic [WIDTH-1:0] mdata_in,
  output logic [WIDTH-1:0] mux_out
);
  assign mux_out = read ? mdata_in : bus_out;
endmodule

// File: rtl/register.sv
// register: generic load-enabled register with synchronous clear
module register
  import cpu_pkg::*;
#(
  parameter int               WIDTH       = DATA_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // clear wins over load; otherwise hold
  always_ff @(posedge clk)
    if (clr) q <= RESET_VALUE;
    else if (enable) q <= d;
endmodule

// File: rtl/mdr_unit.sv
// mdr_unit: memory data register fed by a memory/bus source select
module mdr_unit
  import cpu_pkg::*;
#(
  parameter int               WIDTH       = DATA_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             enable,
  input  logic             read,
  input  logic [WIDTH-1:0] bus_out,
  input  logic [WIDTH-1:0] mdata_in,
  output logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] mdr_out
);
  mdr_mux #(.WIDTH(WIDTH)) u_mux (
    .read(read),
    .bus_out(bus_out),
    .mdata_in(mdata_in),
    .mux_out(mux_out)
  );
  register #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_reg (
    .clk(clk),
    .clr(clr),
    .enable(enable),
    .d(mux_out),
    .q(mdr_out)
  );
endmodule

// File: tb/tb_mdr_unit.sv
// tb_mdr_unit: directed and random checks of mdr_unit against a behavioural model
module tb_mdr_unit;
  logic clk = 0, clr, enable, read;
  logic [31:0] bus_out, mdata_in, mux_out, mdr_out;
  logic [31:0] exp_mdr;
  logic mdr_known = 0;
  int n_checks = 0, n_fail = 0;

  mdr_unit dut (
    .clk(clk),
    .clr(clr),
    .enable(enable),
    .read(read),
    .bus_out(bus_out),
    .mdata_in(mdata_in),
    .mux_out(mux_out),
    .mdr_out(mdr_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // drive one cycle: mux checked before the edge, MDR checked before and after it
  task automatic apply(input logic c, input logic e, input logic r,
                       input logic [31:0] b, input logic [31:0] m);
    logic [31:0] sel;
    @(negedge clk);
    clr = c; enable = e; read = r; bus_out = b; mdata_in = m;
    sel = r ? m : b;
    #1;
    check("mux", mux_out, sel);
    if (mdr_known) check("mdr_pre", mdr_out, exp_mdr);
    @(posedge clk);
    if (c) begin
      exp_mdr = 0;
      mdr_known = 1;
    end else if (e) begin
      exp_mdr = sel;
      mdr_known = 1;
    end
    #1;
    if (mdr_known) check("mdr_post", mdr_out, exp_mdr);
  endtask

  initial begin
    clr = 0; enable = 0; read = 0; bus_out = 0; mdata_in = 0;
    apply(1, 1, 1, 32'd420, 32'd69);
    apply(0, 1, 1, 32'd420, 32'd69);
    apply(0, 1, 0, 32'd420, 32'd69);
    apply(0, 0, 1, 32'h12345678, 32'hDEADBEEF);
    apply(0, 0, 0, 32'h12345678, 32'hDEADBEEF);
    apply(0, 0, 1, 32'hDEADBEEF, 32'h12345678);
    apply(1, 1, 1, 32'd420, 32'hFFFFFFFF);
    apply(0, 1, 1, 32'd420, 32'hFFFFFFFF);
    @(negedge clk);
    enable = 0;
    clr = 1;
    #2;
    check("sync_mid", mdr_out, exp_mdr);
    clr = 0;
    @(posedge clk);
    #1;
    check("sync_after", mdr_out, exp_mdr);
    for (int i = 0; i < 200; i++)
      apply($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom, $urandom);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mdr_unit.md
Name: mdr_unit

Overview:
Memory Data Register (MDR) stage of the datapath: a 2:1 source-select mux feeding a clocked, load-enabled register.
- When a memory read is in progress, the register captures data returned from memory.
- Otherwise it captures the value on the internal CPU bus.
- The registered value drives the bus/memory side. The mux output is also exported for observation.

Parameters:
- WIDTH, 32, data width of bus, memory data and MDR.
- RESET_VALUE, 0, value loaded into the MDR on clr.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  synchronous active-high reset of the MDR.
- enable  in  1  MDR load enable (MDRin).
- read  in  1  source select: 1 = memory data, 0 = CPU bus.
- bus_out  in  WIDTH  value currently driven on the internal CPU bus.
- mdata_in  in  WIDTH  data returned from memory.
- mux_out  out  WIDTH  combinational mux result (the MDR D input).
- mdr_out  out  WIDTH  registered MDR contents.

Behaviour:
- Mux: mux_out = read ? mdata_in : bus_out. Purely combinational, zero latency, no latching.
- If read is X/Z, mux_out is X in simulation; no defaulting is required.
- Register, evaluated on each rising clk edge:
  - if clr = 1: mdr_out <= RESET_VALUE (0), regardless of enable and read.
  - else if enable = 1: mdr_out <= mux_out.
  - else: mdr_out holds its value.
- Precedence: clr > enable.
- Reset is synchronous only. Asserting clr between edges does not change mdr_out until the next rising edge.
- Latency: a value on the selected source appears on mdr_out one rising edge after it is captured (enable = 1 at that edge).
- Reset value: mdr_out = 0 after the first edge with clr = 1. Before any reset or load, mdr_out is X in simulation; no power-on value is required.
- Switching read mid-cycle changes mux_out immediately. mdr_out changes only at the next enabled edge.
- No width extension or truncation: both sources and the register are exactly WIDTH bits.
- No handshake; the control unit sequences read and enable.

Decomposition:
- Shared package (cpu_pkg): DATA_WIDTH = 32, plus a word_t typedef of logic [DATA_WIDTH-1:0]. These are reused by all datapath registers.
- Two sub-modules, instantiated by mdr_unit:
  - mdr_mux: combinational 2:1 select.
  - register: generic WIDTH-bit register with clk, clr, enable, d, q. The same register module serves PC, IR, MAR, etc.

Test Plan:
- Reset: clr = 1 for one edge with enable = 1, read = 1, mdata_in = 69 -> mdr_out = 0 after the edge; mux_out = 69 throughout.
- Memory load: clr = 0, enable = 1, read = 1, mdata_in = 69, bus_out = 420 -> mux_out = 69 immediately; mdr_out = 69 after the next rising edge.
- Bus load: from the previous state, drop read to 0 between edges -> mux_out = 420 immediately; mdr_out stays 69 until the next edge, then becomes 420.
- Hold: enable = 0, toggle read and change both sources (e.g. 0xDEADBEEF, 0x12345678) over 3 edges -> mdr_out stays at its prior value; mux_out tracks the selected source.
- Clear priority: mdr_out = 420, then clr = 1 with enable = 1, read = 1, mdata_in = 0xFFFFFFFF -> mdr_out = 0 after the edge. Release clr -> next edge loads 0xFFFFFFFF.
- Sync-reset check: pulse clr high and low entirely between two edges -> mdr_out unchanged.
